i2s_sample_port: RTL and testbench
==================================

I2S_SAMPLE_PORT -- requirements
Module: i2s_sample_port

Interface
REQ-001 Parameter data_width, default 16: sample width in bits, MSB-first on the wire.
REQ-002 Parameter slot_bits_min, default 17: minimum BCLK rising edges per channel slot (data_width plus 1 delay bit).
REQ-003 Port clk  in  1: system clock; one clock for the whole block.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Ports bclk, lrclk, sdin  in  1 each: asynchronous I2S slave inputs. lrclk=0 selects the left slot.
REQ-006 Port sdout  out  1: I2S serial data to the DAC.
REQ-007 Port sample_out  out  data_width: the last captured left sample, held stable until the next capture.
REQ-008 Port sample_ready  out  1: one-cycle strobe indicating sample_out is new.
REQ-009 Port engine_sample  in  data_width: processed sample from the engine.
REQ-010 Port engine_ready  in  1: engine idle/ready level; its 0->1 transition marks engine_sample valid.
REQ-011 Port overrun  out  1: sticky flag; a new sample arrived while the engine was busy.
REQ-012 Port frame_error  out  1: one-cycle strobe on a short slot.

Function
REQ-013 bclk, lrclk and sdin SHALL each pass through a 2-flop synchronizer plus one edge register; edges are detected 3 clk cycles after the pin changes.
REQ-014 FSM states: SYNC, LEFT, RIGHT.
- SYNC -> LEFT on a synchronized lrclk falling edge.
- LEFT -> RIGHT on an lrclk rising edge.
- RIGHT -> LEFT on an lrclk falling edge.
REQ-015 Every lrclk edge SHALL clear bit_idx (6-bit, saturating at 63). Each bclk rising edge SHALL increment bit_idx.
REQ-016 Capture: in LEFT, on a bclk rising edge with bit_idx in 1..data_width (pre-increment), sdin SHALL be shifted into rx_shift LSB-ward. bit_idx 0 is the I2S delay bit. RIGHT slot data is ignored.
REQ-017 Sample completion: the cycle after the rising edge at bit_idx=data_width in LEFT, sample_out <= rx_shift and sample_ready=1 for exactly one cycle. This requires engine_ready=1 at that cycle.
REQ-018 If engine_ready=0 at completion, no strobe SHALL be issued, sample_out SHALL keep its old value, and overrun SHALL be set.
REQ-019 TX latch: an engine_ready 0->1 transition SHALL copy engine_sample to tx_hold and set tx_valid.
REQ-020 On the lrclk falling edge that enters LEFT, tx_shift <= tx_hold and tx_valid is cleared. tx_hold is retained, so the last value repeats if the engine is late.
REQ-021 Drive: on each bclk falling edge with bit_idx in 1..data_width, sdout SHALL take tx_shift MSB and then shift left. Otherwise sdout=0.
REQ-022 In the RIGHT slot, sdout SHALL be 0 (see Configuration).
REQ-023 An lrclk edge coinciding with a bclk falling edge in the same clk cycle: the lrclk edge is processed first (bit_idx=0, sdout=0).
REQ-024 An lrclk edge arriving while bit_idx < slot_bits_min in LEFT or RIGHT SHALL pulse frame_error, discard rx_shift, emit no sample_ready, and return to SYNC.
REQ-025 In SYNC, no capture SHALL occur and sdout SHALL be 0.

Reset
REQ-026 During reset: state=SYNC; bit_idx, rx_shift, tx_shift and tx_hold = 0; tx_valid=0; sample_out=0; sample_ready=0; sdout=0; overrun=0; frame_error=0.
REQ-027 Reset mid-slot SHALL abort the slot. Capture resumes only after the next lrclk falling edge.
REQ-028 overrun SHALL clear only on reset.

Configuration
REQ-029 Macro I2S_STEREO_DUP_EN.
- Defined: the RIGHT slot reloads tx_shift from tx_hold on the lrclk rising edge and transmits the same sample on both channels.
- Undefined: the RIGHT slot transmits zeros (mono-left DAC).

Verification
REQ-030 Reset, then a 32-bclk-per-slot frame with left=0x1234, engine_ready=1 -> one sample_ready pulse, sample_out=0x1234, overrun=0.
REQ-031 Pulse engine_ready 0->1 with engine_sample=0xA5C3, then run the next frame -> sdout left bits = 1010010111000011 starting at bit_idx 1, zeros after.
REQ-032 Hold engine_ready=0 during left capture of 0x7FFF -> no strobe, sample_out unchanged, overrun=1 held through 3 further frames.
REQ-033 lrclk toggles after 10 bclk rising edges in LEFT -> frame_error one-cycle pulse, no sample_ready. The next full frame captures correctly.
REQ-034 Build with and without I2S_STEREO_DUP_EN, tx_hold=0x8001 -> RIGHT slot sdout is 0x8001 and 0x0000 respectively.
REQ-035 Assert reset at bit_idx 8 of LEFT -> all outputs 0 next cycle. The first following sample_ready appears only after a complete new left slot.

Source files
------------

// File: rtl/i2s_sample_port.sv
// I2S slave sample port: captures the left slot into sample_out and serialises the
// engine's sample back onto sdout. Optional feature macro: I2S_STEREO_DUP_EN.
module i2s_sample_port #(
  parameter int data_width    = 16,
  parameter int slot_bits_min = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  sdin,
  output logic                  sdout,
  output logic [data_width-1:0] sample_out,
  output logic                  sample_ready,
  input  logic [data_width-1:0] engine_sample,
  input  logic                  engine_ready,
  output logic                  overrun,
  output logic                  frame_error,
  output logic [2:0]            debug
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  localparam logic [5:0] dw_idx  = 6'(data_width);
  localparam logic [5:0] min_idx = 6'(slot_bits_min);

`ifdef I2S_STEREO_DUP_EN
  localparam bit dup_en = 1'b1;
`else
  localparam bit dup_en = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [2:0]            bclk_sr, lrclk_sr, sdin_sr;
  logic                  bclk_rise, bclk_fall, lr_rise, lr_fall, lr_edge;
  logic [5:0]            bit_idx;
  logic                  in_data, short_slot;
  logic                  capture_en, complete_en, drive_en, enter_left, enter_right;
  logic                  complete_q, eng_rdy_q, eng_rise, tx_valid;
  logic [data_width-1:0] rx_shift, tx_shift, tx_hold;

  // [0],[1] synchronise the pin, [2] is the previous value for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sr  <= '0;
      lrclk_sr <= '0;
      sdin_sr  <= '0;
    end else begin
      bclk_sr  <= {bclk_sr[1:0], bclk};
      lrclk_sr <= {lrclk_sr[1:0], lrclk};
      sdin_sr  <= {sdin_sr[1:0], sdin};
    end
  end

  assign bclk_rise  = bclk_sr[1] & ~bclk_sr[2];
  assign bclk_fall  = ~bclk_sr[1] & bclk_sr[2];
  assign lr_rise    = lrclk_sr[1] & ~lrclk_sr[2];
  assign lr_fall    = ~lrclk_sr[1] & lrclk_sr[2];
  assign lr_edge    = lr_rise | lr_fall;
  assign in_data    = (bit_idx != 6'd0) && (bit_idx <= dw_idx);
  assign short_slot = (state_q != ST_SYNC) && lr_edge && (bit_idx < min_idx);
  assign eng_rise   = engine_ready & ~eng_rdy_q;
  assign debug      = {tx_valid, state_q};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (lr_fall) state_d = ST_LEFT;
      ST_LEFT, ST_RIGHT: begin
        if (short_slot)   state_d = ST_SYNC;
        else if (lr_fall) state_d = ST_LEFT;
        else if (lr_rise) state_d = ST_RIGHT;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // lrclk edges take priority over any bclk edge seen in the same cycle.
  always_comb begin
    capture_en  = 1'b0;
    complete_en = 1'b0;
    drive_en    = 1'b0;
    case (state_q)
      ST_LEFT: begin
        capture_en  = bclk_rise && !lr_edge && in_data;
        complete_en = capture_en && (bit_idx == dw_idx);
        drive_en    = bclk_fall && !lr_edge && in_data;
      end
      ST_RIGHT: drive_en = dup_en && bclk_fall && !lr_edge && in_data;
      default: ;
    endcase
    enter_left  = lr_fall && (state_d == ST_LEFT);
    enter_right = lr_rise && (state_d == ST_RIGHT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_hold      <= '0;
      tx_valid     <= 1'b0;
      complete_q   <= 1'b0;
      sample_out   <= '0;
      sample_ready <= 1'b0;
      overrun      <= 1'b0;
      frame_error  <= 1'b0;
      sdout        <= 1'b0;
      // Tracking the level during reset avoids a false 0->1 latch on release.
      eng_rdy_q    <= engine_ready;
    end else begin
      eng_rdy_q <= engine_ready;

      if (lr_edge)                              bit_idx <= '0;
      else if (bclk_rise && bit_idx != 6'd63)   bit_idx <= bit_idx + 6'd1;

      if (short_slot)      rx_shift <= '0;
      else if (capture_en) rx_shift <= {rx_shift[data_width-2:0], sdin_sr[2]};

      complete_q   <= complete_en;
      sample_ready <= complete_q & engine_ready;
      if (complete_q && engine_ready) sample_out <= rx_shift;
      if (complete_q && !engine_ready) overrun <= 1'b1;
      frame_error <= short_slot;

      if (eng_rise)        tx_hold <= engine_sample;
      if (eng_rise)        tx_valid <= 1'b1;
      else if (enter_left) tx_valid <= 1'b0;

      if (enter_left || (dup_en && enter_right)) tx_shift <= tx_hold;
      else if (drive_en)                         tx_shift <= tx_shift << 1;

      if (drive_en)                                           sdout <= tx_shift[data_width-1];
      else if (lr_edge || bclk_fall || state_q == ST_SYNC)    sdout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_sample_port.sv
// Bench for i2s_sample_port: directed frame table plus randomized frames checked
// against a frame-level model of capture, transmit, overrun and slot errors.
module tb_i2s_sample_port;
  localparam int DW       = 16;
  localparam int SLOT_MIN = 17;
  localparam int HALF     = 6;

  logic          clk = 1'b0;
  logic          reset, bclk, lrclk, sdin, sdout;
  logic [DW-1:0] sample_out, engine_sample;
  logic          sample_ready, engine_ready, overrun, frame_error;
  logic [2:0]    debug;

  always #5 clk = ~clk;

  i2s_sample_port #(.data_width(DW), .slot_bits_min(SLOT_MIN)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdin(sdin),
    .sdout(sdout), .sample_out(sample_out), .sample_ready(sample_ready),
    .engine_sample(engine_sample), .engine_ready(engine_ready),
    .overrun(overrun), .frame_error(frame_error), .debug(debug)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Strobe monitor: counts high cycles so a stretched pulse shows up as >1.
  int            rdy_cnt  = 0;
  int            ferr_cnt = 0;
  logic [DW-1:0] rdy_last = '0;
  always @(negedge clk) begin
    if (sample_ready) begin
      rdy_cnt  = rdy_cnt + 1;
      rdy_last = sample_out;
    end
    if (frame_error) ferr_cnt = ferr_cnt + 1;
  end

  logic [DW-1:0] m_tx_hold, m_sample;
  logic          m_ovr;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] left;
    logic          do_pulse;
    logic [DW-1:0] eng;
    logic          ready_lo;
    int            lbits;
    logic [DW-1:0] exp_tx;
    logic [DW-1:0] exp_sample;
    logic          exp_rdy;
    logic          exp_ovr;
    logic          exp_ferr;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected wire image of a slot: word MSB-first at positions 1..DW, zero elsewhere.
  function automatic logic [63:0] slot_expect(input logic [DW-1:0] tx, input int nbits);
    logic [63:0]   e = '0;
    logic [DW-1:0] w = tx;
    for (int p = 1; p < nbits && p <= DW; p++) begin
      e = e | (64'(w[DW-1]) << p);
      w = w << 1;
    end
    return e;
  endfunction

  task automatic set_ready(input logic v);
    if (v && !engine_ready) m_tx_hold = engine_sample;
    engine_ready = v;
    @(posedge clk); #1;
  endtask

  task automatic pulse_engine(input logic [DW-1:0] s);
    set_ready(1'b0);
    engine_sample = s;
    set_ready(1'b1);
  endtask

  task automatic reset_mid;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_sample_out", 64'(sample_out), 64'h0);
    check("rst_sample_ready", 64'(sample_ready), 64'h0);
    check("rst_sdout", 64'(sdout), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    check("rst_frame_error", 64'(frame_error), 64'h0);
    check("rst_state", 64'(debug[1:0]), 64'h0);
    reset = 1'b0;
    m_tx_hold = '0;
    m_sample  = '0;
    m_ovr     = 1'b0;
  endtask

  task automatic send_slot(input logic lr, input logic [DW-1:0] word, input int nbits,
                           input int rst_pos, output logic [63:0] sd);
    logic [DW-1:0] w = word;
    sd = '0;
    for (int p = 0; p < nbits; p++) begin
      bclk = 1'b0;
      if (p == 0) lrclk = lr;
      if (p >= 1 && p <= DW) begin
        sdin = w[DW-1];
        w = w << 1;
      end else begin
        sdin = 1'b0;
      end
      repeat (HALF) @(posedge clk);
      #1;
      sd = sd | (64'(sdout) << p);
      bclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      if (p == rst_pos) reset_mid();
    end
  endtask

  task automatic run_frame(input string tag, input logic [DW-1:0] left, input int lbits,
                           input logic ready_lo, input int rst_pos, input logic [DW-1:0] exp_tx,
                           input logic [DW-1:0] exp_sample, input logic exp_rdy,
                           input logic exp_ovr, input logic exp_ferr);
    logic [63:0] sd_l, sd_r, exp_r;
    int base_r, base_f;
    base_r = rdy_cnt;
    base_f = ferr_cnt;
    if (ready_lo) set_ready(1'b0);
    if (exp_rdy) exp_q.push_back(exp_sample);
    send_slot(1'b0, left, lbits, rst_pos, sd_l);
    send_slot(1'b1, 16'($urandom_range(0, 65535)), 32, -1, sd_r);
`ifdef I2S_STEREO_DUP_EN
    exp_r = (lbits >= SLOT_MIN && rst_pos < 0) ? slot_expect(exp_tx, 32) : 64'h0;
`else
    exp_r = 64'h0;
`endif
    check({tag, "_ready_pulses"}, 64'(rdy_cnt - base_r), 64'(exp_rdy));
    check({tag, "_frame_error"}, 64'(ferr_cnt - base_f), 64'(exp_ferr));
    check({tag, "_sample_out"}, 64'(sample_out), 64'(exp_sample));
    check({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr));
    if (rst_pos < 0) check({tag, "_sdout_left"}, sd_l, slot_expect(exp_tx, lbits));
    check({tag, "_sdout_right"}, sd_r, exp_r);
    if (exp_q.size() > 0) check({tag, "_cap_value"}, 64'(rdy_last), 64'(exp_q.pop_front()));
    if (ready_lo) set_ready(1'b1);
  endtask

  initial begin
    logic [DW-1:0] left, eng, exp_tx, exp_sample;
    logic          ready_lo, exp_rdy, exp_ferr, good;
    int            lbits;

    tbl[0]  = '{16'h1234, 1'b0, 16'h0000, 1'b0, 32, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{16'h0F0F, 1'b1, 16'hA5C3, 1'b0, 32, 16'hA5C3, 16'h0F0F, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{16'h7FFF, 1'b0, 16'h0000, 1'b1, 32, 16'hA5C3, 16'h0F0F, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'h0001, 1'b0, 16'h0000, 1'b0, 32, 16'hA5C3, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{16'h8000, 1'b1, 16'h8001, 1'b0, 32, 16'h8001, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{16'hFFFF, 1'b0, 16'h0000, 1'b0, 32, 16'h8001, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{16'h5555, 1'b0, 16'h0000, 1'b0, 10, 16'h8001, 16'hFFFF, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{16'h2468, 1'b0, 16'h0000, 1'b0, 32, 16'h8001, 16'h2468, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{16'h00FF, 1'b0, 16'h0000, 1'b0, 17, 16'h8001, 16'h00FF, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{16'h1111, 1'b0, 16'h0000, 1'b0, 16, 16'h8001, 16'h00FF, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{16'hBEEF, 1'b0, 16'h0000, 1'b0, 32, 16'h8001, 16'hBEEF, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    bclk = 1'b1;
    lrclk = 1'b1;
    sdin = 1'b0;
    engine_ready = 1'b1;
    engine_sample = '0;
    m_tx_hold = '0;
    m_sample = '0;
    m_ovr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_sample_out", 64'(sample_out), 64'h0);
    check("reset_sample_ready", 64'(sample_ready), 64'h0);
    check("reset_sdout", 64'(sdout), 64'h0);
    check("reset_overrun", 64'(overrun), 64'h0);
    check("reset_frame_error", 64'(frame_error), 64'h0);
    check("reset_debug", 64'(debug), 64'h0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_pulse) pulse_engine(tbl[i].eng);
      run_frame($sformatf("vec%0d", i), tbl[i].left, tbl[i].lbits, tbl[i].ready_lo, -1,
                tbl[i].exp_tx, tbl[i].exp_sample, tbl[i].exp_rdy, tbl[i].exp_ovr,
                tbl[i].exp_ferr);
    end

    // Reset after bit_idx reaches 8 in the left slot; the slot is abandoned.
    run_frame("rst_abort", 16'h3C3C, 32, 1'b0, 7, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_frame("rst_after", 16'hC3C3, 32, 1'b0, -1, 16'h0000, 16'hC3C3, 1'b1, 1'b0, 1'b0);
    m_sample = 16'hC3C3;

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        eng = 16'($urandom_range(0, 65535));
        pulse_engine(eng);
      end
      left     = 16'($urandom_range(0, 65535));
      ready_lo = ($urandom_range(0, 3) == 0);
      lbits    = ($urandom_range(0, 4) == 0) ? $urandom_range(4, SLOT_MIN - 1)
                                             : $urandom_range(SLOT_MIN, 32);
      good     = (lbits >= SLOT_MIN);
      exp_tx   = m_tx_hold;
      exp_rdy  = good && !ready_lo;
      exp_ferr = !good;
      if (exp_rdy) m_sample = left;
      if (good && ready_lo) m_ovr = 1'b1;
      exp_sample = m_sample;
      run_frame($sformatf("rnd%0d", i), left, lbits, ready_lo, -1, exp_tx, exp_sample,
                exp_rdy, m_ovr, exp_ferr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
